// File: rtl/minute_hour_counter_pkg.sv
// Shared limits and BCD helpers for the minute/hour timekeeping block.
package minute_hour_counter_pkg;

  localparam int DIGIT_W  = 4;
  localparam int MAX_MIN  = 59;
  localparam int MAX_HOUR = 23;
  localparam int NOON     = 12;

  typedef logic [DIGIT_W-1:0] digit_t;

  function automatic logic [6:0] bcd_value(input digit_t tens, input digit_t ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

  // Advance a two-digit BCD count by one, wrapping to 00 after max_val.
  function automatic logic [2*DIGIT_W-1:0] bcd_inc(input digit_t tens, input digit_t ones,
                                                   input int max_val);
    if (bcd_value(tens, ones) == 7'(max_val))
      return '0;
    else if (ones == digit_t'(9))
      return {tens + digit_t'(1), digit_t'(0)};
    else
      return {tens, ones + digit_t'(1)};
  endfunction

  function automatic logic [2*DIGIT_W-1:0] to_bcd(input logic [6:0] v);
    return {digit_t'(v / 7'd10), digit_t'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/minute_hour_counter_rise_detect.sv
// Rising-edge detector: flags the cycle where the input is high and was low last cycle.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/minute_hour_counter.sv
// BCD minute/hour timekeeper with set mode, midnight day-carry pulse and 12h/24h display.
module minute_hour_counter
  import minute_hour_counter_pkg::*;
#(
  parameter int RESET_HOUR = 0,
  parameter int RESET_MIN  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       change_minute,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hour,
  input  logic       mode_12h,
  output logic [3:0] right_min,
  output logic [3:0] left_min,
  output logic [3:0] right_hour,
  output logic [3:0] left_hour,
  output logic       pm,
  output logic       change_day
);

  localparam digit_t RST_MIN_TENS  = digit_t'(RESET_MIN / 10);
  localparam digit_t RST_MIN_ONES  = digit_t'(RESET_MIN % 10);
  localparam digit_t RST_HOUR_TENS = digit_t'(RESET_HOUR / 10);
  localparam digit_t RST_HOUR_ONES = digit_t'(RESET_HOUR % 10);

  digit_t     min_tens, min_ones, hour_tens, hour_ones;
  digit_t     min_tens_nx, min_ones_nx, hour_tens_nx, hour_ones_nx;
  logic       cm_evt, im_evt, ih_evt;
  logic       tick, min_at_max, hour_at_max, adv_min, adv_hour, day_roll;
  logic [6:0] hour_bin, disp_bin;

  rise_detect u_cm (.clk(clk), .rst(rst), .level(change_minute), .rise(cm_evt));
  rise_detect u_im (.clk(clk), .rst(rst), .level(inc_min),       .rise(im_evt));
  rise_detect u_ih (.clk(clk), .rst(rst), .level(inc_hour),      .rise(ih_evt));

  // Timekeeping ticks are dropped in set mode; button events only count in set mode.
  assign tick        = cm_evt & ~set_mode;
  assign min_at_max  = bcd_value(min_tens, min_ones) == 7'(MAX_MIN);
  assign hour_at_max = bcd_value(hour_tens, hour_ones) == 7'(MAX_HOUR);
  assign adv_min     = tick | (set_mode & im_evt);
  assign adv_hour    = (tick & min_at_max) | (set_mode & ih_evt);
  assign day_roll    = tick & min_at_max & hour_at_max;

  always_comb begin
    {min_tens_nx, min_ones_nx}   = {min_tens, min_ones};
    {hour_tens_nx, hour_ones_nx} = {hour_tens, hour_ones};
    if (adv_min)  {min_tens_nx, min_ones_nx}   = bcd_inc(min_tens, min_ones, MAX_MIN);
    if (adv_hour) {hour_tens_nx, hour_ones_nx} = bcd_inc(hour_tens, hour_ones, MAX_HOUR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_tens   <= RST_MIN_TENS;
      min_ones   <= RST_MIN_ONES;
      hour_tens  <= RST_HOUR_TENS;
      hour_ones  <= RST_HOUR_ONES;
      change_day <= 1'b0;
    end else begin
      min_tens   <= min_tens_nx;
      min_ones   <= min_ones_nx;
      hour_tens  <= hour_tens_nx;
      hour_ones  <= hour_ones_nx;
      change_day <= day_roll;
    end
  end

  // Display path is purely combinational so mode_12h never touches the stored time.
  assign hour_bin = bcd_value(hour_tens, hour_ones);

  always_comb begin
    disp_bin = hour_bin;
    if (mode_12h) begin
      if (hour_bin == 7'd0)             disp_bin = 7'(NOON);
      else if (hour_bin > 7'(NOON))     disp_bin = hour_bin - 7'(NOON);
    end
  end

  assign {left_hour, right_hour} = to_bcd(disp_bin);
  assign left_min  = min_tens;
  assign right_min = min_ones;
  assign pm        = hour_bin >= 7'(NOON);

endmodule

// File: tb/tb_minute_hour_counter.sv
// Bench for minute_hour_counter: directed scenarios plus randomized traffic against a minute-of-day model.
module tb_minute_hour_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       change_minute = 1'b0;
  logic       set_mode = 1'b0;
  logic       inc_min = 1'b0;
  logic       inc_hour = 1'b0;
  logic       mode_12h = 1'b0;
  logic [3:0] right_min, left_min, right_hour, left_hour;
  logic       pm, change_day;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  int m_hour = 0;
  int m_min  = 0;
  bit m_cd   = 1'b0;
  bit p_cm = 1'b0, p_im = 1'b0, p_ih = 1'b0;

  always #5 clk = ~clk;

  minute_hour_counter dut (
    .clk(clk), .rst(rst), .change_minute(change_minute), .set_mode(set_mode),
    .inc_min(inc_min), .inc_hour(inc_hour), .mode_12h(mode_12h),
    .right_min(right_min), .left_min(left_min), .right_hour(right_hour),
    .left_hour(left_hour), .pm(pm), .change_day(change_day)
  );

  // Reference: time held as hour and minute integers, advanced via minute-of-day arithmetic.
  task automatic model_step();
    bit e_cm, e_im, e_ih;
    int total;
    if (rst) begin
      m_hour = 0; m_min = 0; m_cd = 1'b0;
      p_cm = 1'b0; p_im = 1'b0; p_ih = 1'b0;
    end else begin
      e_cm = change_minute && !p_cm;
      e_im = inc_min && !p_im;
      e_ih = inc_hour && !p_ih;
      m_cd = 1'b0;
      if (!set_mode && e_cm) begin
        total = m_hour * 60 + m_min + 1;
        if (total == 24 * 60) begin
          total = 0;
          m_cd  = 1'b1;
        end
        m_hour = total / 60;
        m_min  = total % 60;
      end
      if (set_mode) begin
        if (e_im) m_min  = (m_min + 1) % 60;
        if (e_ih) m_hour = (m_hour + 1) % 24;
      end
      p_cm = change_minute; p_im = inc_min; p_ih = inc_hour;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  function automatic logic [17:0] model_out();
    int dh;
    dh = m_hour;
    if (mode_12h) dh = (m_hour % 12 == 0) ? 12 : m_hour % 12;
    return {m_cd, m_hour >= 12, 4'(dh / 10), 4'(dh % 10), 4'(m_min / 10), 4'(m_min % 10)};
  endfunction

  function automatic logic [17:0] dut_out();
    return {change_day, pm, left_hour, right_hour, left_min, right_min};
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      n_checks++;
      if (dut_out() === model_out()) n_pass++;
      else $display("FAIL cycle_cmp t=%0t got %h expected %h", $time, dut_out(), model_out());
    end
  end

  task automatic check_lit(input string name, input logic [17:0] exp);
    n_checks++;
    if (dut_out() === exp) n_pass++;
    else $display("FAIL %s t=%0t got %h expected %h", name, $time, dut_out(), exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic press_min(input int n);
    repeat (n) begin
      inc_min = 1'b1; change_minute = 1'($urandom_range(0, 1)); step();
      inc_min = 1'b0; step();
    end
    change_minute = 1'b0; step();
  endtask

  task automatic press_hour(input int n);
    repeat (n) begin
      inc_hour = 1'b1; change_minute = 1'($urandom_range(0, 1)); step();
      inc_hour = 1'b0; step();
    end
    change_minute = 1'b0; step();
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) step();
    check_en = 1'b1;
    step();
    check_lit("reset_state", {2'b00, 16'h0000});

    rst = 1'b0; step();
    check_lit("idle_after_release", {2'b00, 16'h0000});
    change_minute = 1'b1; step();
    check_lit("first_minute", {2'b00, 16'h0001});
    change_minute = 1'b0; step();

    set_mode = 1'b1; step();
    press_hour(23); press_min(58);
    check_lit("preload_2359", {2'b01, 16'h2359});
    set_mode = 1'b0; step();
    change_minute = 1'b1; step();
    check_lit("midnight_pulse", {2'b10, 16'h0000});
    step();
    check_lit("pulse_one_cycle", {2'b00, 16'h0000});
    repeat (50) step();
    check_lit("held_no_advance", {2'b00, 16'h0000});
    change_minute = 1'b0; step();

    set_mode = 1'b1; step();
    press_hour(10); press_min(59);
    check_lit("set_1059", {2'b00, 16'h1059});
    press_min(1);
    check_lit("inc_min_no_carry", {2'b00, 16'h1000});
    press_hour(1);
    check_lit("inc_hour", {2'b00, 16'h1100});
    press_hour(12); press_min(59);
    check_lit("set_2359", {2'b01, 16'h2359});
    inc_min = 1'b1; inc_hour = 1'b1; change_minute = 1'b1; step();
    check_lit("both_wrap", {2'b00, 16'h0000});
    inc_min = 1'b0; inc_hour = 1'b0; change_minute = 1'b0; step();
    check_lit("no_day_in_set", {2'b00, 16'h0000});

    mode_12h = 1'b1; step();
    check_lit("12h_midnight", {2'b00, 16'h1200});
    press_hour(12);
    check_lit("12h_noon", {2'b01, 16'h1200});
    press_hour(1);
    check_lit("12h_1pm", {2'b01, 16'h0100});
    mode_12h = 1'b0; step();
    check_lit("24h_13", {2'b01, 16'h1300});

    press_hour(1); press_min(37);
    change_minute = 1'b1; step();
    set_mode = 1'b0; repeat (3) step();
    check_lit("pre_reset_1437", {2'b01, 16'h1437});
    rst = 1'b1; #1;
    check_lit("async_reset", {2'b00, 16'h0000});
    step(); step();
    rst = 1'b0; step();
    check_lit("post_release_event", {2'b00, 16'h0001});
    repeat (5) step();
    check_lit("single_advance", {2'b00, 16'h0001});
    change_minute = 1'b0; step();

    repeat (4000) begin
      change_minute = 1'($urandom_range(0, 1));
      inc_min  = ($urandom_range(0, 2) == 0);
      inc_hour = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) set_mode = ~set_mode;
      if ($urandom_range(0, 29) == 0) mode_12h = ~mode_12h;
      if ($urandom_range(0, 799) == 0) rst = 1'b1;
      step();
      rst = 1'b0;
    end

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
